// File: rtl/pulse_scheduler.sv
// Multi-channel delayed-event scheduler: prescaled base tick, per-channel
// countdown, and a round-robin valid/ready event output.
module pulse_scheduler #(
  parameter int NCH       = 4,
  parameter int DIV_COUNT = 25,
  parameter int DW        = 8
) (
  input  logic                    clk50,
  input  logic                    rst,
  input  logic [NCH-1:0]          req,
  input  logic [NCH*DW-1:0]       delay,
  output logic [NCH-1:0]          ack,
  output logic [NCH-1:0]          busy,
  output logic                    tick,
  output logic                    evt_valid,
  output logic [$clog2(NCH)-1:0]  evt_id,
  input  logic                    evt_ready
);

  localparam int IW = $clog2(NCH);
  localparam int CW = $clog2(DIV_COUNT) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PENDING = 2'd2
  } ch_state_t;

  ch_state_t       r_st  [NCH];
  logic [DW-1:0]   r_rem [NCH];
  logic [NCH-1:0]  r_ack;
  logic [CW-1:0]   r_cnt;
  logic            r_valid;
  logic [IW-1:0]   r_id;
  logic [IW-1:0]   r_rr;

  logic            w_tick;
  logic            w_xfer;
  logic            w_found;
  logic [IW-1:0]   w_pick;
  logic [IW-1:0]   w_idx;
  int              w_sum;
  logic [NCH-1:0]  w_pend;
  logic [NCH-1:0]  w_busy;

  assign w_tick = (r_cnt == CW'(DIV_COUNT));
  assign w_xfer = r_valid && evt_ready;

  always_ff @(posedge clk50) begin
    if (rst || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_pend = '0;
    w_busy = '0;
    for (int i = 0; i < NCH; i++) begin
      w_pend[i] = (r_st[i] == PENDING);
      w_busy[i] = (r_st[i] != IDLE);
    end
  end

  // Round-robin scan starting at r_rr, wrapping at NCH.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = 0;
    w_idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      w_sum = int'(r_rr) + k;
      if (w_sum >= NCH) begin
        w_sum = w_sum - NCH;
      end
      w_idx = IW'(w_sum);
      if (!w_found && w_pend[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      r_ack <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_st[i]  <= IDLE;
        r_rem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_ack[i] <= 1'b0;
        unique case (r_st[i])
          IDLE: begin
            if (req[i]) begin
              r_ack[i] <= 1'b1;
              r_rem[i] <= delay[i*DW +: DW];
              r_st[i]  <= (delay[i*DW +: DW] == '0) ? PENDING : ARMED;
            end
          end
          ARMED: begin
            if (w_tick) begin
              r_rem[i] <= r_rem[i] - 1'b1;
              if (r_rem[i] == DW'(1)) begin
                r_st[i] <= PENDING;
              end
            end
          end
          PENDING: begin
            if (w_xfer && r_id == IW'(i)) begin
              r_st[i] <= IDLE;
            end
          end
          default: r_st[i] <= IDLE;
        endcase
      end
    end
  end

  // Selection only while idle keeps evt_id stable across backpressure.
  always_ff @(posedge clk50) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_id    <= '0;
      r_rr    <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b0;
      r_rr    <= (r_id == IW'(NCH-1)) ? '0 : r_id + 1'b1;
    end else if (!r_valid && w_found) begin
      r_valid <= 1'b1;
      r_id    <= w_pick;
    end
  end

  assign ack       = r_ack;
  assign busy      = w_busy;
  assign tick      = w_tick;
  assign evt_valid = r_valid;
  assign evt_id    = r_id;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler with a cycle-level reference model
// derived from tick arithmetic and round-robin rules.
module tb_pulse_scheduler;

  localparam int PER = 26;

  logic        clk50 = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] delay;
  logic [3:0]  ack;
  logic [3:0]  busy;
  logic        tick;
  logic        evt_valid;
  logic [1:0]  evt_id;
  logic        evt_ready;

  int nvec = 0;
  int nerr = 0;
  int now  = 0;

  pulse_scheduler #(
    .NCH(4),
    .DIV_COUNT(25),
    .DW(8)
  ) dut (
    .clk50(clk50),
    .rst(rst),
    .req(req),
    .delay(delay),
    .ack(ack),
    .busy(busy),
    .tick(tick),
    .evt_valid(evt_valid),
    .evt_id(evt_id),
    .evt_ready(evt_ready)
  );

  initial forever #10 clk50 = ~clk50;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s cycle %0d: got %0h want %0h", nm, now, got, exp);
    end
  endtask

  // Cycle at which a channel accepted at the end of cycle c with delay d
  // first reads PENDING: the d-th tick strictly after c, plus one.
  function automatic int pend_at(input int c, input int d);
    int t1;
    if (d == 0) return c + 1;
    t1 = (c / PER) * PER + (PER - 1);
    if (t1 <= c) t1 = t1 + PER;
    return t1 + PER * (d - 1) + 1;
  endfunction

  int       m_cyc;
  bit       m_init = 1'b0;
  bit [3:0] m_busy;
  bit [3:0] m_ack;
  int       m_pend [4];
  bit       m_valid;
  int       m_id;
  int       m_rr;

  always @(posedge clk50) begin : model
    bit [3:0] idle0;
    int sel;
    int c;
    if (rst) begin
      m_init  = 1'b1;
      m_cyc   = 0;
      m_busy  = '0;
      m_ack   = '0;
      m_valid = 1'b0;
      m_id    = 0;
      m_rr    = 0;
    end else if (m_init) begin
      idle0 = ~m_busy;
      if (m_valid && evt_ready) begin
        m_busy[m_id] = 1'b0;
        m_valid      = 1'b0;
        m_rr         = (m_id + 1) % 4;
      end else if (!m_valid) begin
        sel = -1;
        for (int k = 0; k < 4; k++) begin
          c = (m_rr + k) % 4;
          if (sel < 0 && m_busy[c] && m_cyc >= m_pend[c]) sel = c;
        end
        if (sel >= 0) begin
          m_valid = 1'b1;
          m_id    = sel;
        end
      end
      for (int i = 0; i < 4; i++) begin
        m_ack[i] = idle0[i] && req[i];
        if (m_ack[i]) begin
          m_busy[i] = 1'b1;
          m_pend[i] = pend_at(m_cyc, int'(delay[i*8 +: 8]));
        end
      end
      m_cyc++;
    end
  end

  always @(negedge clk50) begin
    if (m_init) begin
      check("m_tick", {31'b0, tick}, {31'b0, (m_cyc % PER) == PER - 1});
      check("m_ack", {28'b0, ack}, {28'b0, m_ack});
      check("m_busy", {28'b0, busy}, {28'b0, m_busy});
      check("m_valid", {31'b0, evt_valid}, {31'b0, m_valid});
      check("m_id", {30'b0, evt_id}, m_id);
    end
  end

  task automatic go(input int n);
    while (now < n) begin
      @(posedge clk50);
      #1;
      now++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(posedge clk50);
    @(posedge clk50);
    #1;
    rst = 1'b0;
    now = 0;
  endtask

  task automatic req_at(input int n, input logic [3:0] m,
                        input logic [7:0] d);
    go(n);
    for (int i = 0; i < 4; i++) begin
      if (m[i]) delay[i*8 +: 8] = d;
    end
    req = req | m;
    go(n + 1);
    req = req & ~m;
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    delay     = '0;
    evt_ready = 1'b1;

    // idle run: tick only at 25, 51, 77
    do_reset();
    check("rst_busy", {28'b0, busy}, 32'h0);
    check("rst_valid", {31'b0, evt_valid}, 32'h0);
    go(24); check("tick24", {31'b0, tick}, 32'h0);
    go(25); check("tick25", {31'b0, tick}, 32'h1);
    go(26); check("tick26", {31'b0, tick}, 32'h0);
    go(51); check("tick51", {31'b0, tick}, 32'h1);
    go(77); check("tick77", {31'b0, tick}, 32'h1);
    go(80); check("idle_busy", {28'b0, busy}, 32'h0);

    // delay 3 on ch0, delay 0 on ch2
    do_reset();
    req_at(2, 4'b0001, 8'd3);
    check("ack0_c3", {28'b0, ack}, 32'h1);
    go(4);
    check("ack0_c4", {28'b0, ack}, 32'h0);
    check("busy_c4", {28'b0, busy}, 32'h1);
    req_at(10, 4'b0100, 8'd0);
    check("ack2_c11", {28'b0, ack}, 32'h4);
    check("busy_c11", {28'b0, busy}, 32'h5);
    go(12);
    check("v_c12", {31'b0, evt_valid}, 32'h1);
    check("id_c12", {30'b0, evt_id}, 32'h2);
    go(13);
    check("v_c13", {31'b0, evt_valid}, 32'h0);
    check("busy_c13", {28'b0, busy}, 32'h1);
    go(78); check("v_c78", {31'b0, evt_valid}, 32'h0);
    go(79);
    check("v_c79", {31'b0, evt_valid}, 32'h1);
    check("id_c79", {30'b0, evt_id}, 32'h0);
    go(80);
    check("busy_c80", {28'b0, busy}, 32'h0);
    check("v_c80", {31'b0, evt_valid}, 32'h0);

    // simultaneous expiry on ch1/ch3, then rr back at 0
    do_reset();
    req_at(5, 4'b1010, 8'd1);
    check("ack13", {28'b0, ack}, 32'ha);
    go(26); check("v_c26", {31'b0, evt_valid}, 32'h0);
    go(27);
    check("v_c27", {31'b0, evt_valid}, 32'h1);
    check("id_c27", {30'b0, evt_id}, 32'h1);
    go(28);
    check("v_c28", {31'b0, evt_valid}, 32'h0);
    check("busy_c28", {28'b0, busy}, 32'h8);
    go(29);
    check("v_c29", {31'b0, evt_valid}, 32'h1);
    check("id_c29", {30'b0, evt_id}, 32'h3);
    req_at(40, 4'b0101, 8'd0);
    check("ack02", {28'b0, ack}, 32'h5);
    go(42); check("id_c42", {30'b0, evt_id}, 32'h0);
    go(44); check("id_c44", {30'b0, evt_id}, 32'h2);

    // backpressure for 10 cycles, then re-request
    do_reset();
    evt_ready = 1'b0;
    req_at(3, 4'b0010, 8'd0);
    check("ack1_c4", {28'b0, ack}, 32'h2);
    req_at(4, 4'b0001, 8'd0);
    for (int k = 5; k < 15; k++) begin
      go(k);
      check("hold_v", {31'b0, evt_valid}, 32'h1);
      check("hold_id", {30'b0, evt_id}, 32'h1);
    end
    go(15);
    evt_ready = 1'b1;
    go(16);
    check("bp_v16", {31'b0, evt_valid}, 32'h0);
    check("bp_busy16", {28'b0, busy}, 32'h1);
    req_at(16, 4'b0010, 8'd0);
    check("reack1", {28'b0, ack}, 32'h2);
    check("bp_id17", {30'b0, evt_id}, 32'h0);
    go(19);
    check("bp_v19", {31'b0, evt_valid}, 32'h1);
    check("bp_id19", {30'b0, evt_id}, 32'h1);

    // reset while armed, overriding req and evt_ready
    do_reset();
    req_at(2, 4'b0001, 8'd5);
    check("arm_busy", {28'b0, busy}, 32'h1);
    go(30);
    rst = 1'b1;
    req = 4'b0100;
    go(31);
    check("mr_busy", {28'b0, busy}, 32'h0);
    check("mr_ack", {28'b0, ack}, 32'h0);
    rst = 1'b0;
    req = '0;
    now = 0;
    for (int k = 20; k <= 200; k += 20) begin
      go(k);
      check("mr_novalid", {31'b0, evt_valid}, 32'h0);
    end
    go(201);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pulse_scheduler.md
PULSE_SCHEDULER -- requirements
Module: pulse_scheduler

Interface
REQ-001 SHALL provide parameter NCH, default 4: number of requester channels.
REQ-002 SHALL provide parameter DIV_COUNT, default 25: prescaler terminal count; base tick period is DIV_COUNT+1 cycles.
REQ-003 SHALL provide parameter DW, default 8: delay field width per channel.
REQ-004 SHALL have clk50  input  1  clock, all logic on rising edge.
REQ-005 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have req  input  NCH  per-channel request; requester holds it high until ack.
REQ-007 SHALL have delay  input  NCH*DW  flattened; channel i uses bits [i*DW +: DW], in base ticks.
REQ-008 SHALL have ack  output  NCH  one-cycle acceptance pulse per channel.
REQ-009 SHALL have busy  output  NCH  channel state not IDLE.
REQ-010 SHALL have tick  output  1  base tick, high one cycle per prescaler period.
REQ-011 SHALL have evt_valid  output  1  expired-event output valid.
REQ-012 SHALL have evt_id  output  $clog2(NCH)  channel index of presented event.
REQ-013 SHALL have evt_ready  input  1  downstream accepts event.

Function
REQ-014 Prescaler counter SHALL count 0..DIV_COUNT then wrap to 0; tick SHALL be high exactly while counter==DIV_COUNT.
REQ-015 Counter width SHALL be $clog2(DIV_COUNT)+1 bits; no other wrap point.
REQ-016 Each channel SHALL have states IDLE, ARMED, PENDING, plus a DW-bit remaining count.
REQ-017 IDLE with req[i] high at edge T: SHALL capture delay, assert ack[i] during cycle T+1 only, enter ARMED (delay>0) or PENDING (delay==0) at T+1.
REQ-018 req[i] while channel not IDLE SHALL be ignored: no ack, no capture.
REQ-019 ARMED: each tick SHALL decrement remaining; tick with remaining==1 SHALL enter PENDING next cycle.
REQ-020 A tick in the same cycle a request is captured SHALL NOT decrement the new count; countdown starts at the next tick.
REQ-021 Output arbiter SHALL select among PENDING channels round-robin, starting from pointer rr, only when evt_valid is low.
REQ-022 Selection SHALL be registered: evt_valid/evt_id assert the cycle after a channel is seen PENDING with evt_valid low.
REQ-023 evt_valid and evt_id SHALL hold stable until evt_valid && evt_ready.
REQ-024 On transfer: that channel SHALL return to IDLE, rr SHALL become evt_id+1 mod NCH, evt_valid SHALL drop next cycle; min one idle cycle between events.
REQ-025 Multiple channels expiring on one tick SHALL all become PENDING and be served in round-robin order; none lost.
REQ-026 Channel may be re-requested the cycle after returning to IDLE.
REQ-027 busy[i] SHALL be high in ARMED and PENDING, including while its event is presented.

Reset
REQ-028 On rst: counter=0, tick=0, all channels IDLE, remaining=0, ack=0, busy=0, evt_valid=0, evt_id=0, rr=0.
REQ-029 rst mid-operation SHALL discard all armed and pending events; no event emitted for them afterward.
REQ-030 rst SHALL override req, tick, and evt_ready in the same cycle.

Verification (NCH=4, DIV_COUNT=25, DW=8; cycle 0 = first cycle after rst deasserts)
REQ-031 Idle run -> tick high at cycles 25, 51, 77 only; all other outputs 0.
REQ-032 req[0], delay=3 sampled at edge ending cycle 2; evt_ready=1 -> ack[0] at cycle 3; PENDING cycle 78; evt_valid=1, evt_id=0 at cycle 79; busy[0]=0 from cycle 80.
REQ-033 req[2], delay=0 sampled at cycle 10 -> ack[2] and busy[2] at 11; evt_valid, evt_id=2 at 12.
REQ-034 req[1] and req[3], delay=1, both accepted before cycle 25; evt_ready=1 -> evt_id=1 at cycle 27, evt_valid=0 at 28, evt_id=3 at 29, rr=0 after.
REQ-035 Event presented with evt_ready=0 for 10 cycles -> evt_valid, evt_id unchanged all 10 cycles; transfer on first evt_ready=1.
REQ-036 rst pulsed while channel 0 ARMED (delay=5) -> busy=0 next cycle; no evt_valid through cycle 200.
